mem_access_stage: RTL

- MEM stage of the 64-bit SIMD/AES pipeline; sits between the EX/MEM register and the MEM/WB register and drives its MEM_* inputs.
- Non-memory instructions pass through with 1-cycle latency.
- Loads and stores run a variable-latency req/ack transaction on the data-memory port and stall the upstream pipeline until it completes.

---
 rtl/mem_access_stage_if.sv | 39 +++
 rtl/mem_access_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory port bundle for the MEM stage.
// Macro: none.
// Signals:
//   mem_req   - request, held high for the whole access
//   mem_we    - 1 = write, 0 = read
//   mem_addr  - doubleword address
//   mem_wdata - store data
//   mem_ack   - completion strobe from memory
//   mem_rdata - read data, valid together with mem_ack
// Modports: master (pipeline side), slave (memory side).
interface mem_access_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 64-bit SIMD/AES pipeline. Sits between EX/MEM and MEM/WB.
// Non-memory instructions pass through in one cycle; loads/stores run a
// variable-latency req/ack transaction and stall upstream until it completes.
// Optional macro: MEM_ACCESS_TIMEOUT_EN enables a watchdog that abandons an
// access after TIMEOUT_CYC cycles without ack and sets the sticky mem_err.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   ex_valid, EX_*          - instruction from EX/MEM (held stable while stall=1)
//   stall                   - hold EX/MEM and earlier stages
//   mem (master modport)    - data-memory req/ack port
//   MEM_*                   - registered results to MEM/WB
//   mem_err                 - sticky timeout flag (0 when the watchdog is absent)
module mem_access_stage #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [DATA_W-1:0]         EX_ALUResult,
  input  logic [DATA_W-1:0]         EX_StoreData,
  input  logic [4:0]                EX_rd,
  input  logic                      EX_MemRead,
  input  logic                      EX_MemWrite,
  input  logic                      EX_MemToReg,
  input  logic                      EX_RegWrite,
  output logic                      stall,
  mem_access_stage_if.master        mem,
  output logic [DATA_W-1:0]         MEM_MemData,
  output logic [DATA_W-1:0]         MEM_ALUResult,
  output logic [4:0]                MEM_rd,
  output logic                      MEM_MemToReg,
  output logic                      MEM_RegWrite,
  output logic                      mem_err
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [4:0]        rd_q, rd_d;
  logic              m2r_q, m2r_d;
  logic              rw_q, rw_d;
  logic              memop;
  logic              timeout;

  assign memop = ex_valid & (EX_MemRead | EX_MemWrite);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // Bubble by default; only a retiring instruction loads real values.
    data_d  = '0;
    alu_d   = '0;
    rd_d    = '0;
    m2r_d   = 1'b0;
    rw_d    = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memop) begin
          stall   = 1'b1;
          state_d = StAccess;
          req_d   = 1'b1;
          // Write wins when both read and write are requested.
          we_d    = EX_MemWrite;
          addr_d  = EX_ALUResult[ADDR_W+2:3];
          wdata_d = EX_StoreData;
        end else begin
          alu_d = EX_ALUResult;
          rd_d  = EX_rd;
          rw_d  = EX_RegWrite & ex_valid;
          m2r_d = EX_MemToReg & ex_valid;
        end
      end
      StAccess: begin
        if (mem.mem_ack) begin
          // EX_* is still the instruction that started this access.
          state_d = StIdle;
          req_d   = 1'b0;
          data_d  = we_q ? '0 : mem.mem_rdata;
          alu_d   = EX_ALUResult;
          rd_d    = EX_rd;
          rw_d    = EX_RegWrite & ex_valid;
          m2r_d   = EX_MemToReg & ex_valid;
        end else if (timeout) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Fires in the ACCESS cycle that would be the TIMEOUT_CYC-th without ack.
  assign timeout = (state_q == StAccess) && !mem.mem_ack &&
                   (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_q == StIdle) && memop) begin
      cnt_d = '0;
    end else if ((state_q == StAccess) && !mem.mem_ack) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign MEM_MemData   = data_q;
  assign MEM_ALUResult = alu_q;
  assign MEM_rd        = rd_q;
  assign MEM_MemToReg  = m2r_q;
  assign MEM_RegWrite  = rw_q;

endmodule
